// File: rtl/decode_pipe_ctrl_if.sv
// Decode-stage handshake bundle.
// Carries the fetch-side request (in_valid/in_ready/instr/pc_in), the registered
// ID/EX control bundle with its valid/ready handshake, and the load-use bubble
// counter.
//   master : environment side (fetch drives instr, execute drives out_ready)
//   slave  : decode stage (drives in_ready and the whole ID/EX bundle)
// PC_WIDTH and CNT_WIDTH must match the parameters of the attached decode_pipe_ctrl.
interface decode_pipe_ctrl_if #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
);
  // fetch -> decode
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr;
  logic [PC_WIDTH-1:0]  pc_in;
  // decode -> execute (ID/EX register)
  logic                 out_valid;
  logic                 out_ready;
  logic [PC_WIDTH-1:0]  pc_out;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [4:0]           rd;
  logic [2:0]           funct3_out;
  logic [3:0]           ALUctrl;
  logic                 ALUSrc;
  logic [1:0]           ALUSrcA;
  logic [2:0]           ImmSrc;
  logic                 RegWrite;
  logic                 MemWrite;
  logic                 MemRead;
  logic                 Branch;
  logic                 Jump;
  logic                 PcOp;
  logic [1:0]           ResultSrc;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] bubble_cnt;

  modport master (
    output in_valid, instr, pc_in, out_ready,
    input  in_ready, out_valid, pc_out, rs1, rs2, rd, funct3_out, ALUctrl,
           ALUSrc, ALUSrcA, ImmSrc, RegWrite, MemWrite, MemRead, Branch,
           Jump, PcOp, ResultSrc, illegal, bubble_cnt
  );

  modport slave (
    input  in_valid, instr, pc_in, out_ready,
    output in_ready, out_valid, pc_out, rs1, rs2, rd, funct3_out, ALUctrl,
           ALUSrc, ALUSrcA, ImmSrc, RegWrite, MemWrite, MemRead, Branch,
           Jump, PcOp, ResultSrc, illegal, bubble_cnt
  );
endinterface

// File: rtl/decode_pipe_ctrl.sv
// Pipelined RV32I decode/control stage.
// Decodes the incoming instruction combinationally and registers the control
// bundle into the ID/EX register under a valid/ready handshake. A load in ID/EX
// whose rd is read by the incoming instruction holds off fetch for one cycle
// and lets a bubble through (counted in bubble_cnt, saturating). flush kills
// both the ID/EX content and the incoming instruction.
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset (wins over flush)
//   flush : discard ID/EX and incoming instruction
//   bus   : decode_pipe_ctrl_if.slave -- fetch request, ID/EX bundle, bubble_cnt
// ALUctrl encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7,
//                   OR 8, AND 9.
module decode_pipe_ctrl #(
  parameter int unsigned PC_WIDTH       = 32,
  parameter bit          LOAD_USE_STALL = 1'b1,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  decode_pipe_ctrl_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [1:0] alu_src_a;
    logic [2:0] imm_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       pc_op;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_t;

  // Register/immediate ALU op from funct3; alt selects SUB (R only) or SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt,
                                        input logic allow_sub);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch comparison op: EQ/NE subtract, signed LT/GE use SLT, unsigned SLTU.
  function automatic logic [3:0] branch_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3[2:1])
      2'b10:   op = ALU_SLT;
      2'b11:   op = ALU_SLTU;
      default: op = ALU_SUB;
    endcase
    return op;
  endfunction

  ctrl_t                dec;
  ctrl_t                idex_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] bubble_q;

  logic [6:0] opcode;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       hazard;
  logic       in_ready_c;
  logic       bubble;
  logic       unused_instr_bits;

  assign opcode            = bus.instr[6:0];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:25]};

  always_comb begin
    dec        = '0;
    dec.rs1    = bus.instr[19:15];
    dec.rs2    = bus.instr[24:20];
    dec.rd     = bus.instr[11:7];
    dec.funct3 = bus.instr[14:12];
    case (opcode)
      OP_R: begin
        dec.alu_ctrl  = alu_op(bus.instr[14:12], bus.instr[30], 1'b1);
        dec.reg_write = 1'b1;
      end
      OP_I_ALU: begin
        // funct7[5] of an ADDI is immediate data, so it must never select SUB.
        dec.alu_ctrl  = alu_op(bus.instr[14:12], bus.instr[30], 1'b0);
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_I;
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_ctrl   = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_I;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.result_src = RES_MEM;
      end
      OP_STORE: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_S;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.alu_ctrl = branch_op(bus.instr[14:12]);
        dec.imm_src  = IMM_B;
        dec.branch   = 1'b1;
      end
      OP_JAL: begin
        dec.alu_ctrl   = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.alu_src_a  = SRCA_PC;
        dec.imm_src    = IMM_J;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_JALR: begin
        dec.alu_ctrl   = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.alu_src_a  = SRCA_RS1;
        dec.imm_src    = IMM_I;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.pc_op      = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_LUI: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = SRCA_ZERO;
        dec.imm_src   = IMM_U;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = SRCA_PC;
        dec.imm_src   = IMM_U;
        dec.reg_write = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Which source fields the incoming instruction really reads; U/J formats
  // carry immediate bits there and must not raise a false interlock.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I_ALU, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    if (LOAD_USE_STALL && valid_q && idex_q.mem_read && (idex_q.rd != 5'd0)) begin
      hazard = (uses_rs1 && (idex_q.rd == bus.instr[19:15])) ||
               (uses_rs2 && (idex_q.rd == bus.instr[24:20]));
    end
  end

  // flush always accepts so fetch is never blocked while redirecting.
  assign in_ready_c = flush || ((!valid_q || bus.out_ready) && !hazard);
  // Only a real pending instruction being held off counts as a bubble.
  assign bubble     = hazard && bus.in_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q   <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      bubble_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (bus.in_valid && in_ready_c) begin
      idex_q  <= dec;
      pc_q    <= bus.pc_in;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
      if (bubble && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = valid_q;
  assign bus.pc_out     = pc_q;
  assign bus.rs1        = idex_q.rs1;
  assign bus.rs2        = idex_q.rs2;
  assign bus.rd         = idex_q.rd;
  assign bus.funct3_out = idex_q.funct3;
  assign bus.ALUctrl    = idex_q.alu_ctrl;
  assign bus.ALUSrc     = idex_q.alu_src;
  assign bus.ALUSrcA    = idex_q.alu_src_a;
  assign bus.ImmSrc     = idex_q.imm_src;
  assign bus.RegWrite   = idex_q.reg_write;
  assign bus.MemWrite   = idex_q.mem_write;
  assign bus.MemRead    = idex_q.mem_read;
  assign bus.Branch     = idex_q.branch;
  assign bus.Jump       = idex_q.jump;
  assign bus.PcOp       = idex_q.pc_op;
  assign bus.ResultSrc  = idex_q.result_src;
  assign bus.illegal    = idex_q.illegal;
  assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
module tb_decode_pipe_ctrl;

  logic clk;
  logic rst;
  logic flush;

  int total = 0;
  int bad   = 0;

  decode_pipe_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) bus ();

  decode_pipe_ctrl #(
    .PC_WIDTH      (32),
    .LOAD_USE_STALL(1'b1),
    .CNT_WIDTH     (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src;
    logic [1:0]  srca;
    logic [2:0]  imm;
    logic        rw;
    logic        mw;
    logic        mr;
    logic        br;
    logic        j;
    logic        pcop;
    logic [1:0]  res;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(
    input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic [2:0] f3, input logic [3:0] alu,
    input logic src, input logic [1:0] srca, input logic [2:0] imm,
    input logic rw, input logic mw, input logic mr, input logic br,
    input logic j, input logic pcop, input logic [1:0] res, input logic ill);
    exp_t e;
    e = '{pc: pc, rs1: rs1, rs2: rs2, rd: rd, f3: f3, alu: alu, src: src,
          srca: srca, imm: imm, rw: rw, mw: mw, mr: mr, br: br, j: j,
          pcop: pcop, res: res, ill: ill};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Scoreboard monitor: compares every ID/EX transfer against the queue head.
  always @(negedge clk) begin
    exp_t act;
    exp_t want;
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      act = '{pc: bus.pc_out, rs1: bus.rs1, rs2: bus.rs2, rd: bus.rd,
              f3: bus.funct3_out, alu: bus.ALUctrl, src: bus.ALUSrc,
              srca: bus.ALUSrcA, imm: bus.ImmSrc, rw: bus.RegWrite,
              mw: bus.MemWrite, mr: bus.MemRead, br: bus.Branch,
              j: bus.Jump, pcop: bus.PcOp, res: bus.ResultSrc, ill: bus.illegal};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: got %h want none", act);
      end else begin
        want = sb.pop_front();
        if (act !== want) begin
          bad++;
          $display("FAIL xfer pc=%h: got %h want %h", want.pc, act, want);
        end
      end
    end
  end

  // One fetch cycle: present, check in_ready, record expected transfer, clock.
  task automatic cycle(input logic iv, input logic [31:0] ins, input exp_t e,
                       input logic rdy_exp, input string tag);
    bus.in_valid = iv;
    bus.instr    = ins;
    bus.pc_in    = e.pc;
    #1;
    chk({"in_ready_", tag}, 32'(bus.in_ready), 32'(rdy_exp));
    if (iv && rdy_exp && !flush && !rst) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLT = 4'd3, SLTU = 4'd4, SRA = 4'd7;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_ADD6  = 32'h00228333;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_SLTIU = 32'h0050B393;
  localparam logic [31:0] I_SRAI  = 32'h40325213;
  localparam logic [31:0] I_BGEU  = 32'h0020F463;
  localparam logic [31:0] I_ADDI  = 32'hFFF00093;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  task automatic check_cleared(input string tag);
    chk({"out_valid_", tag},  32'(bus.out_valid), 32'd0);
    chk({"bubble_cnt_", tag}, 32'(bus.bubble_cnt), 32'd0);
    chk({"pc_out_", tag},     bus.pc_out, 32'd0);
    chk({"rd_", tag},         32'(bus.rd), 32'd0);
    chk({"RegWrite_", tag},   32'(bus.RegWrite), 32'd0);
    chk({"ALUctrl_", tag},    32'(bus.ALUctrl), 32'd0);
    chk({"in_ready_", tag},   32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    exp_t e_none;
    e_none = '0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.pc_in = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    // ADD then load-use bubble
    bus.out_ready = 1'b1;
    cycle(1, I_ADD, mk(32'h100, 1, 2, 3, 0, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, "add");
    chk("out_valid_add", 32'(bus.out_valid), 32'd1);
    chk("rd_add", 32'(bus.rd), 32'd3);
    cycle(1, I_LW, mk(32'h104, 1, 0, 5, 2, ADD, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0), 1, "lw");
    cycle(1, I_ADD6, mk(32'h108, 5, 2, 6, 0, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, "stall");
    chk("out_valid_bubble", 32'(bus.out_valid), 32'd0);
    chk("bubble_cnt_1", 32'(bus.bubble_cnt), 32'd1);
    cycle(1, I_ADD6, mk(32'h108, 5, 2, 6, 0, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, "add6");

    // load then LUI writing same rd: no interlock
    cycle(1, I_LW, mk(32'h10C, 1, 0, 5, 2, ADD, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0), 1, "lw2");
    cycle(1, I_LUI, mk(32'h110, 8, 3, 5, 5, ADD, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0), 1, "lui");
    chk("bubble_cnt_lui", 32'(bus.bubble_cnt), 32'd1);

    // BNE held for three cycles
    cycle(1, I_BNE, mk(32'h114, 1, 2, 8, 1, SUB, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0), 1, "bne");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, I_SLTIU, mk(32'h118, 1, 5, 7, 3, SLTU, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, "hold");
      chk("pc_out_hold", bus.pc_out, 32'h114);
      chk("ALUctrl_hold", 32'(bus.ALUctrl), 32'(SUB));
      chk("out_valid_hold", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    cycle(1, I_SLTIU, mk(32'h118, 1, 5, 7, 3, SLTU, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, "sltiu");
    cycle(1, I_SRAI, mk(32'h11C, 4, 3, 4, 5, SRA, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, "srai");
    cycle(1, I_BGEU, mk(32'h120, 1, 2, 8, 7, SLTU, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0), 1, "bgeu");
    cycle(1, I_ADDI, mk(32'h124, 0, 31, 1, 0, ADD, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, "addi");
    cycle(1, I_SUB, mk(32'h128, 1, 2, 3, 0, SUB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, "sub");

    // flush while a load-use hazard is pending: no bubble counted
    cycle(1, I_LW, mk(32'h200, 1, 0, 5, 2, ADD, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0), 1, "lw3");
    flush = 1'b1;
    cycle(1, I_ADD6, mk(32'h204, 5, 2, 6, 0, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, "flush");
    flush = 1'b0;
    sb.delete();
    chk("out_valid_flush", 32'(bus.out_valid), 32'd0);
    chk("bubble_cnt_flush", 32'(bus.bubble_cnt), 32'd1);

    // JALR, illegal opcode, then drain
    cycle(1, I_JALR, mk(32'h300, 2, 0, 1, 0, ADD, 1, 0, 0, 1, 0, 0, 0, 1, 1, 2, 0), 1, "jalr");
    cycle(1, I_ILL, mk(32'h304, 0, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, "ill");
    cycle(0, 32'h0, e_none, 1, "drain");
    chk("out_valid_drain", 32'(bus.out_valid), 32'd0);

    // reset while stalled
    cycle(1, I_ADD, mk(32'h308, 1, 2, 3, 0, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, "add2");
    bus.out_ready = 1'b0;
    cycle(1, I_SUB, mk(32'h30C, 1, 2, 3, 0, SUB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, "hold2");
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check_cleared("rst_hold");
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
